// File: rtl/unified_mem_arbiter.sv
// Unified instruction/data memory shared by CHANNELS requesters through a round-robin arbiter.
// Build option: define UMEM_FIXED_PRIORITY_EN for fixed lowest-index-wins arbitration.
module unified_mem_arbiter #(
    parameter int CHANNELS    = 2,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [CHANNELS-1:0]     reqValid,
    input  logic [CHANNELS-1:0]     reqWrite,
    input  logic [CHANNELS*32-1:0]  reqAddress,
    input  logic [CHANNELS*32-1:0]  reqStoreData,
    input  logic [CHANNELS*4-1:0]   reqByteEnable,
    output logic [CHANNELS-1:0]     reqReady,
    output logic [CHANNELS-1:0]     respValid,
    output logic [CHANNELS-1:0]     storeComplete,
    output logic [CHANNELS-1:0]     respError,
    output logic [31:0]             respData
);

    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WORD_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY - 1);
    localparam logic [32:0]      BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic {IDLE, BUSY} arbState;

    arbState              state;
    arbState              stateNext;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     countNext;

    logic [IDX_W-1:0]     grantIdx_p1;
    logic                 grantWrite_p1;
    logic                 grantError_p1;
    logic [31:0]          holdData_p1;

    logic [31:0]          mem [DEPTH_WORDS];

    logic                 respCycle;
    logic                 canGrant;
    logic                 accept;
    logic                 pickValid;
    logic [IDX_W-1:0]     pickIdx;

    logic                 selWrite;
    logic [31:0]          selAddress;
    logic [31:0]          selStoreData;
    logic [3:0]           selByteEnable;
    logic                 outOfRange;
    logic [WORD_W-1:0]    wordIdx;
    logic [CHANNELS-1:0]  respOneHot;

    assign respCycle = (state == BUSY) && (count == '0);
    assign canGrant  = !reset && ((state == IDLE) || respCycle);
    assign accept    = canGrant && pickValid;

`ifdef UMEM_FIXED_PRIORITY_EN
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (reqValid[i]) begin
                pickValid = 1'b1;
                pickIdx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rrPointer;
    logic [IDX_W-1:0] candIdx;

    // Walk from the farthest offset back to pointer+1 so the nearest requester wins last.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        candIdx   = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            candIdx = IDX_W'((int'(rrPointer) + i) % CHANNELS);
            if (reqValid[candIdx]) begin
                pickValid = 1'b1;
                pickIdx   = candIdx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rrPointer <= IDX_W'(CHANNELS - 1);
        end else if (accept) begin
            rrPointer <= pickIdx;
        end
    end
`endif

    always_comb begin
        selWrite      = 1'b0;
        selAddress    = '0;
        selStoreData  = '0;
        selByteEnable = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pickIdx == IDX_W'(i)) begin
                selWrite      = reqWrite[i];
                selAddress    = reqAddress[32*i +: 32];
                selStoreData  = reqStoreData[32*i +: 32];
                selByteEnable = reqByteEnable[4*i +: 4];
            end
        end
    end

    assign outOfRange = ({1'b0, selAddress} >= BYTE_LIMIT);
    assign wordIdx    = selAddress[WORD_W+1:2];
    assign reqReady   = accept ? (CHANNELS'(1) << pickIdx) : '0;

    always_comb begin
        stateNext = state;
        countNext = count;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = BUSY;
                    countNext = CNT_RELOAD;
                end
            end
            BUSY: begin
                if (count != '0) begin
                    countNext = count - CNT_W'(1);
                end else if (accept) begin
                    countNext = CNT_RELOAD;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                countNext = '0;
            end
        endcase
    end

    // Accept edge -> p1: latch the winner, its kind and range status, and the load word.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            grantIdx_p1   <= '0;
            grantWrite_p1 <= 1'b0;
            grantError_p1 <= 1'b0;
            holdData_p1   <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
            if (accept) begin
                grantIdx_p1   <= pickIdx;
                grantWrite_p1 <= selWrite;
                grantError_p1 <= outOfRange;
                if (!selWrite) begin
                    holdData_p1 <= outOfRange ? '0 : mem[wordIdx];
                end
            end
        end
    end

    // Stores commit at their accept edge, so a reset while BUSY cannot undo them.
    always_ff @(posedge clock) begin
        if (accept && selWrite && !outOfRange) begin
            for (int b = 0; b < 4; b++) begin
                if (selByteEnable[b]) begin
                    mem[wordIdx][8*b +: 8] <= selStoreData[8*b +: 8];
                end
            end
        end
    end

    assign respOneHot    = CHANNELS'(1) << grantIdx_p1;
    assign respValid     = (respCycle && !reset && !grantWrite_p1) ? respOneHot : '0;
    assign storeComplete = (respCycle && !reset && grantWrite_p1) ? respOneHot : '0;
    assign respError     = (respCycle && !reset && grantError_p1) ? respOneHot : '0;
    assign respData      = reset ? '0 : holdData_p1;

    // Handshake invariants: at most one grant and one response pulse per cycle.
    assert property (@(posedge clock) disable iff (reset) $onehot0(reqReady));
    assert property (@(posedge clock) disable iff (reset) $onehot0(respValid | storeComplete));
    assert property (@(posedge clock) disable iff (reset)
                     ((respError & ~(respValid | storeComplete)) == '0));

endmodule
